inv_shift_rows_stage: RTL

//  Registered AES InvShiftRows stage for the decryption datapath; the inverse of the encrypt-side ShiftRows.

---
 rtl/aes_pkg.sv | 21 ++
 rtl/inv_shift_rows_comb.sv | 20 ++
 rtl/inv_shift_rows_stage.sv | 118 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and helpers for the decrypt datapath stages.
// Byte k of a state is state[127-8k -: 8]; row = k % NB, column = k / NB.
package aes_pkg;

  localparam int NB         = 4;
  localparam int NBYTES     = 16;
  localparam int STATE_BITS = 128;

  typedef logic [STATE_BITS-1:0] state_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

  function automatic logic [7:0] get_byte(input state_t s, input int k);
    return s[STATE_BITS-1-8*k -: 8];
  endfunction

endpackage

// File: rtl/inv_shift_rows_comb.sv
// Purely combinational AES InvShiftRows byte permutation.
// out[r+4c] = in[r+4*((c-r) mod 4)]; row r rotates right by r columns.
module inv_shift_rows_comb
  import aes_pkg::*;
(
  input  state_t in_state,
  output state_t out_state
);

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_byte
      localparam int row = gi % NB;
      localparam int col = gi / NB;
      localparam int src = row + NB * ((col - row + NB) % NB);
      assign out_state[STATE_BITS-1-8*gi -: 8] = get_byte(in_state, src);
    end
  endgenerate

endmodule

// File: rtl/inv_shift_rows_stage.sv
// Registered InvShiftRows stage behind a 2-entry skid buffer (valid/ready both sides).
// Optional output transfer counter on xfer_cnt when INVSR_XFER_CNT_EN is defined.
module inv_shift_rows_stage
  import aes_pkg::*;
#(
  parameter int STATE_W = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               s_enable,
  input  logic [STATE_W-1:0] s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [STATE_W-1:0] m_data
`ifdef INVSR_XFER_CNT_EN
  ,
  output logic [31:0]        xfer_cnt
`endif
);

  generate
    if (STATE_W != STATE_BITS) begin : g_bad_width
      $error("inv_shift_rows_stage: STATE_W must be 128");
    end
  endgenerate

  buf_state_e state_reg, state_next;
  state_t     main_reg, main_next;
  state_t     skid_reg, skid_next;
  logic       s_ready_reg;
  state_t     shifted;
  state_t     in_data;
  logic       in_fire;
  logic       out_fire;

  inv_shift_rows_comb u_perm (
    .in_state  (s_data),
    .out_state (shifted)
  );

  // Permutation (or bypass) happens before the registers; both entries hold final data.
  assign in_data  = s_enable ? shifted : s_data;
  assign in_fire  = s_valid & s_ready_reg;
  assign out_fire = m_valid & m_ready;

  assign m_valid = (state_reg != EMPTY);
  assign m_data  = main_reg;
  assign s_ready = s_ready_reg;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      unique case (state_reg)
        EMPTY: begin
          if (in_fire) begin
            state_next = ONE;
            main_next  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_next = in_data;
          end else if (in_fire) begin
            state_next = TWO;
            skid_next  = in_data;
          end else if (out_fire) begin
            state_next = EMPTY;
          end
        end
        TWO: begin
          // s_ready is low here, so only the drain side can move.
          if (out_fire) begin
            state_next = ONE;
            main_next  = skid_reg;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= EMPTY;
      main_reg    <= '0;
      skid_reg    <= '0;
      s_ready_reg <= 1'b1;
    end else begin
      state_reg   <= state_next;
      main_reg    <= main_next;
      skid_reg    <= skid_next;
      s_ready_reg <= (state_next != TWO);
    end
  end

`ifdef INVSR_XFER_CNT_EN
  logic [31:0] xfer_cnt_reg;

  // Flush wins over a coincident output handshake, so that beat is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_reg <= '0;
    end else if (out_fire && !flush) begin
      xfer_cnt_reg <= xfer_cnt_reg + 32'd1;
    end
  end

  assign xfer_cnt = xfer_cnt_reg;
`endif

endmodule
